// File: rtl/mc_mips_core.sv
// mc_mips_core: multi-cycle MIPS integer core sharing one ready-handshaked memory port.
// Optional feature: define MC_MIPS_BNE_EN to decode bne (opcode 0x05); otherwise it halts.
module mc_mips_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  input  logic [4:0]        dbg_sel,
  output logic [31:0]       dbg_data,
  output logic              instr_retired,
  output logic              halted
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
`ifdef MC_MIPS_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
`endif
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, ir, ir_n, a, a_n, b, b_n, alu_out, alu_n, mdr, mdr_n;
  logic [31:0] regs [32];
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire, take, req_n;
  logic [31:0] addr_n;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sx, br_off;
  logic        funct_ok, xfer;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sx   = {{16{ir[15]}}, ir[15:0]};
  assign br_off   = {{14{ir[15]}}, ir[15:0], 2'b00};
  assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_SLT);
  // mem_ready is meaningless unless a request is actually outstanding
  assign xfer     = mem_req && mem_ready;

  assign dbg_data      = (dbg_sel == 5'd0) ? 32'd0 : regs[dbg_sel];
  assign instr_retired = retire;

  // Next-state and datapath updates, one architectural step per state
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    ir_n     = ir;
    a_n      = a;
    b_n      = b;
    alu_n    = alu_out;
    mdr_n    = mdr;
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = alu_out;
    retire   = 1'b0;
    take     = 1'b0;
    case (state)
      S_FETCH: begin
        if (xfer) begin
          ir_n    = mem_rdata;
          pc_n    = pc + 32'd4;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        a_n = regs[rs];
        b_n = regs[rt];
        case (opcode)
          OP_RTYPE:     state_n = funct_ok ? S_EXEC : S_HALT;
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_BEQ:       state_n = S_BRANCH;
`ifdef MC_MIPS_BNE_EN
          OP_BNE:       state_n = S_BRANCH;
`endif
          OP_ADDI:      state_n = S_ADDIEX;
          OP_J:         state_n = S_JUMP;
          default:      state_n = S_HALT;
        endcase
      end
      S_EXEC: begin
        case (funct)
          FN_ADD:  alu_n = a + b;
          FN_SUB:  alu_n = a - b;
          FN_AND:  alu_n = a & b;
          FN_OR:   alu_n = a | b;
          FN_SLT:  alu_n = {31'd0, ($signed(a) < $signed(b))};
          default: alu_n = alu_out;
        endcase
        state_n = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        rf_wdata = alu_out;
        retire   = 1'b1;
        state_n  = S_FETCH;
      end
      S_MEMADR: begin
        alu_n   = a + imm_sx;
        state_n = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        if (xfer) begin
          mdr_n   = mem_rdata;
          state_n = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = mdr;
        retire   = 1'b1;
        state_n  = S_FETCH;
      end
      S_MEMWR: begin
        if (xfer) begin
          retire  = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_BRANCH: begin
`ifdef MC_MIPS_BNE_EN
        take = (opcode == OP_BNE) ? (a != b) : (a == b);
`else
        take = (a == b);
`endif
        if (take) pc_n = pc + br_off;
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_ADDIEX: begin
        alu_n   = a + imm_sx;
        state_n = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = alu_out;
        retire   = 1'b1;
        state_n  = S_FETCH;
      end
      S_JUMP: begin
        pc_n    = {pc[31:28], ir[25:0], 2'b00};
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_HALT;
    endcase
    // Port outputs are registered from the state being entered
    req_n  = (state_n == S_FETCH) || (state_n == S_MEMRD) || (state_n == S_MEMWR);
    addr_n = (state_n == S_FETCH) ? pc_n : alu_n;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      ir        <= ir_n;
      a         <= a_n;
      b         <= b_n;
      alu_out   <= alu_n;
      mdr       <= mdr_n;
      mem_req   <= req_n;
      mem_we    <= (state_n == S_MEMWR);
      mem_addr  <= ADDR_W'(addr_n);
      mem_wdata <= b_n;
      halted    <= (state_n == S_HALT);
    end
  end

  // Register file; $0 is never written
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_mc_mips_core.sv
// Bench for mc_mips_core: ISA-level reference model feeds a scoreboard of memory
// transactions and per-instruction latencies; a monitor checks them as the core runs.
module tb_mc_mips_core;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, instr_retired, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, dbg_data;
  logic [4:0]  dbg_sel;

  mc_mips_core #(.RESET_PC(32'h0000_0100), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .instr_retired(instr_retired), .halted(halted)
  );

  always #5 clock = ~clock;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] prog [1024];
  logic [31:0] mem  [1024];
  logic [31:0] mm   [1024];
  logic [31:0] mr   [32];
  txn_t        exp_txn [$];
  int          exp_lat [$];
  int          waits = 0;
  bit          hold_ready = 1'b0;
  bit          limit_mode = 1'b0;
  bit          exp_halt;
  int          n_ret;

  // Memory responder and scoreboard monitor
  int cyc = 0, last_ret = -1, wait_cnt = 0;
  always @(negedge clock) begin
    txn_t e;
    int   lat;
    if (reset) begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      wait_cnt  = 0;
      last_ret  = -1;
      n_ret     = 0;
      mem       = prog;
    end else begin
      cyc++;
      mem_ready = 1'b0;
      if (mem_req && !hold_ready) begin
        if (wait_cnt >= waits) begin
          wait_cnt = 0;
          if (exp_txn.size() > 0) begin
            e = exp_txn.pop_front();
            checks++;
            if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data)) begin
              errors++;
              $display("FAIL txn: got we=%0b addr=%h wdata=%h, expected we=%0b addr=%h wdata=%h",
                       mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
            end
          end else if (!limit_mode) begin
            checks++;
            errors++;
            $display("FAIL txn_extra: got we=%0b addr=%h, expected no request", mem_we, mem_addr);
          end
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr[11:2]];
          if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
        end else begin
          wait_cnt++;
        end
      end
      #1;
      if (instr_retired) begin
        n_ret++;
        if (exp_lat.size() > 0) begin
          lat = exp_lat.pop_front();
          if (last_ret >= 0) begin
            checks++;
            if (cyc - last_ret != lat) begin
              errors++;
              $display("FAIL latency: got %0d cycles, expected %0d (retire %0d)", cyc - last_ret, lat, n_ret);
            end
          end
        end else if (!limit_mode) begin
          checks++;
          errors++;
          $display("FAIL retire_extra: got a retire, expected none (retire %0d)", n_ret);
        end
        last_ret = cyc;
      end
    end
  end

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(int tgt);
    return {6'h02, 26'(tgt)};
  endfunction

  // ISA-level interpreter: expected bus traffic, latencies and final register state
  task automatic model_run(input int max_instr);
    logic [31:0] pc, ins, a, b, simm, ea;
    logic [4:0]  rs, rt, rd;
    int          lat;
    bit          stop;
    pc = 32'h100;
    mm = prog;
    for (int i = 0; i < 32; i++) mr[i] = '0;
    exp_halt = 1'b0;
    for (int n = 0; n < max_instr; n++) begin
      ins = mm[pc[11:2]];
      exp_txn.push_back('{we: 1'b0, addr: pc, data: 32'd0});
      pc   = pc + 32'd4;
      rs   = ins[25:21];
      rt   = ins[20:16];
      rd   = ins[15:11];
      a    = mr[rs];
      b    = mr[rt];
      simm = {{16{ins[15]}}, ins[15:0]};
      lat  = 0;
      stop = 1'b0;
      case (ins[31:26])
        6'h00: begin
          lat = 4 + waits;
          case (ins[5:0])
            6'h20: if (rd != 0) mr[rd] = a + b;
            6'h22: if (rd != 0) mr[rd] = a - b;
            6'h24: if (rd != 0) mr[rd] = a & b;
            6'h25: if (rd != 0) mr[rd] = a | b;
            6'h2A: if (rd != 0) mr[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: stop = 1'b1;
          endcase
        end
        6'h08: begin lat = 4 + waits; if (rt != 0) mr[rt] = a + simm; end
        6'h23: begin
          ea  = a + simm;
          lat = 5 + 2 * waits;
          exp_txn.push_back('{we: 1'b0, addr: ea, data: 32'd0});
          if (rt != 0) mr[rt] = mm[ea[11:2]];
        end
        6'h2B: begin
          ea  = a + simm;
          lat = 4 + 2 * waits;
          exp_txn.push_back('{we: 1'b1, addr: ea, data: b});
          mm[ea[11:2]] = b;
        end
        6'h04: begin lat = 3 + waits; if (a == b) pc = pc + (simm << 2); end
`ifdef MC_MIPS_BNE_EN
        6'h05: begin lat = 3 + waits; if (a != b) pc = pc + (simm << 2); end
`endif
        6'h02: begin lat = 3 + waits; pc = {pc[31:28], ins[25:0], 2'b00}; end
        default: stop = 1'b1;
      endcase
      if (stop) begin
        exp_halt = 1'b1;
        break;
      end
      exp_lat.push_back(lat);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic chk_reg(input int idx, input logic [31:0] want);
    dbg_sel = 5'(idx);
    #1;
    chk($sformatf("reg%0d", idx), dbg_data, want);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) prog[i] = HALT_W;
  endtask

  // Reset, preload program into memory and model, run to halt or retire budget
  task automatic run_prog(input string name, input int w, input int max_instr, input bit limit);
    bit done;
    reset = 1'b1;
    waits = w;
    limit_mode = limit;
    exp_txn.delete();
    exp_lat.delete();
    model_run(max_instr);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(posedge clock);
      done = limit ? (n_ret >= max_instr) : halted;
    end
    repeat (3) @(negedge clock);
    #2;
    chk({name, "_done"}, 32'(done), 32'd1);
    if (!limit) begin
      chk({name, "_halted"}, 32'(halted), 32'(exp_halt));
      chk({name, "_req_idle"}, 32'(mem_req), 32'd0);
    end
    chk({name, "_txn_left"}, 32'(exp_txn.size()), 32'd0);
    chk({name, "_lat_left"}, 32'(exp_lat.size()), 32'd0);
    for (int i = 0; i < 32; i++) chk_reg(i, mr[i]);
  endtask

  task automatic gen_random();
    logic [5:0] fns [5];
    int pc;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    clear_prog();
    for (int k = 0; k < 24; k++) begin
      pc = 32'h100 + 4 * k;
      case ($urandom_range(0, 9))
        2, 3, 4: prog[64+k] = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                                    fns[$urandom_range(0, 4)]);
        5: prog[64+k] = enc_i(6'h2B, 0, $urandom_range(0, 7), 32'h800 + $urandom_range(0, 63));
        6: prog[64+k] = enc_i(6'h23, 0, $urandom_range(1, 7), 32'h800 + $urandom_range(0, 63));
        7: prog[64+k] = enc_i(6'h04, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        8: prog[64+k] = enc_j((pc + 4 + 4 * $urandom_range(1, 3)) >> 2);
        default: prog[64+k] = enc_i(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
      endcase
    end
  endtask

  initial begin
    bit seen;
    dbg_sel = 5'd5;
    clear_prog();
    #3;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_retired", 32'(instr_retired), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_dbg", dbg_data, 32'd0);

    // First fetch address, then reset during a stalled fetch
    prog[64] = enc_i(6'h08, 0, 1, 5);
    hold_ready = 1'b1;
    limit_mode = 1'b1;
    @(posedge clock);
    #2 reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clock);
      seen = mem_req;
    end
    chk("first_req", 32'(seen), 32'd1);
    chk("first_addr", mem_addr, 32'h100);
    repeat (3) @(posedge clock);
    #1 chk("stall_hold_addr", mem_addr, 32'h100);
    #1 reset = 1'b1;
    #1 chk("stall_reset_req", 32'(mem_req), 32'd0);
    hold_ready = 1'b0;

    // ALU with $1=5, $2=-3
    clear_prog();
    prog[64] = enc_i(6'h08, 0, 1, 5);
    prog[65] = enc_i(6'h08, 0, 2, -3);
    prog[66] = enc_r(1, 2, 3, 6'h20);
    prog[67] = enc_r(1, 2, 4, 6'h22);
    prog[68] = enc_r(2, 1, 5, 6'h2A);
    prog[69] = enc_r(1, 2, 7, 6'h24);
    prog[70] = enc_r(1, 2, 8, 6'h25);
    prog[71] = enc_i(6'h08, 0, 0, 7);
    run_prog("alu", 0, 200, 1'b0);
    chk_reg(3, 32'd2);
    chk_reg(4, 32'd8);
    chk_reg(5, 32'd1);
    chk_reg(7, 32'd5);
    chk_reg(8, 32'hFFFF_FFFD);
    chk_reg(0, 32'd0);

    // Store/load round trip with 3 wait cycles per transaction
    clear_prog();
    prog[64] = enc_i(6'h08, 0, 1, 32'h40);
    prog[65] = enc_i(6'h2B, 1, 1, 8);
    prog[66] = enc_i(6'h23, 1, 6, 8);
    run_prog("mem", 3, 200, 1'b0);
    chk_reg(6, 32'h40);
    chk("mem_word_48", mem[32'h48 >> 2], 32'h40);

    // Not-taken beq, jump to 0x40, self-looping beq
    clear_prog();
    prog[64] = enc_i(6'h08, 0, 1, 1);
    prog[65] = enc_i(6'h04, 1, 0, 1);
    prog[66] = enc_j(32'h10);
    prog[16] = enc_i(6'h04, 0, 0, -1);
    run_prog("ctrl", 0, 9, 1'b1);

    // Opcode 0x05: taken bne when enabled, halt otherwise
    clear_prog();
    prog[64] = enc_i(6'h08, 0, 1, 1);
    prog[65] = enc_i(6'h08, 0, 2, 2);
    prog[66] = enc_i(6'h05, 1, 2, 1);
    prog[67] = enc_i(6'h08, 0, 3, 9);
    prog[68] = enc_i(6'h08, 0, 4, 4);
    run_prog("bne", 1, 200, 1'b0);
`ifdef MC_MIPS_BNE_EN
    chk_reg(3, 32'd0);
    chk_reg(4, 32'd4);
`else
    chk_reg(2, 32'd2);
    chk_reg(4, 32'd0);
`endif
    chk("bne_halted", 32'(halted), 32'd1);

    // Randomized straight-line programs with forward control flow
    for (int r = 0; r < 5; r++) begin
      gen_random();
      run_prog($sformatf("rand%0d", r), $urandom_range(0, 2), 200, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_mips_core.md
# mc_mips_core

Multi-cycle MIPS core: the next generation of our single-cycle processor. It executes the same integer subset through a state machine, one architectural step per state. All instruction and data traffic goes through a single shared memory port with a ready handshake, so slow or wait-stated memories can be attached. It sits where the single-cycle datapath sat, with instruction ROM and data RAM replaced by one external unified memory.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- ADDR_W, 32: width of mem_addr; the low ADDR_W bits of the byte address are driven.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDR_W  byte address, word aligned by construction for fetch.
- mem_wdata  out  32  store data; valid while mem_req && mem_we.
- mem_ready  in  1  transaction completes on a rising edge where mem_req && mem_ready.
- mem_rdata  in  32  read data; sampled on the completing edge.
- dbg_sel  in  5  register-file read select for debug.
- dbg_data  out  32  combinational read of register dbg_sel; $0 reads 0.
- instr_retired  out  1  one-cycle pulse in the final state of each instruction.
- halted  out  1  high while in HALT.

## Operation
- ISA:
  - R-type, op 0x00, funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
- 32x32 register file. Writes to $0 are discarded.
- States and transitions:
  - FETCH: mem_req=1, mem_we=0, addr=PC. On completion, IR<=mem_rdata, PC<=PC+4, go to DECODE.
  - DECODE: A<=rs, B<=rt. Next state by opcode:
    - R-type -> EXEC
    - lw/sw -> MEMADR
    - beq -> BRANCH
    - addi -> ADDIEX
    - j -> JUMP
    - any other opcode or R funct -> HALT
  - EXEC: ALUOut<=A op B, go to ALUWB.
  - ALUWB: rd<=ALUOut, retire, go to FETCH.
  - MEMADR: ALUOut<=A+signext(imm). lw -> MEMRD, sw -> MEMWR.
  - MEMRD: read at ALUOut, hold until completion, MDR<=mem_rdata, go to MEMWB.
  - MEMWB: rt<=MDR, retire, go to FETCH.
  - MEMWR: write B at ALUOut, hold until completion, retire, go to FETCH.
  - BRANCH: if A==B, PC<=PC+(signext(imm)<<2). Retire, go to FETCH.
  - ADDIEX: ALUOut<=A+signext(imm), go to ADDIWB.
  - ADDIWB: rt<=ALUOut, retire, go to FETCH.
  - JUMP: PC<={PC[31:28], imm26, 2'b00}, retire, go to FETCH.
  - HALT: terminal. No requests; halted=1. Left only by reset.
- Arithmetic:
  - 32-bit, wrap on overflow, no exceptions.
  - slt is signed.
  - imm is sign-extended.
- The memory word select ignores mem_addr[1:0]. The core passes computed data addresses unmodified.

## Timing
- Reset values:
  - PC=RESET_PC, state=FETCH.
  - Registers, IR, A, B, ALUOut, MDR = 0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - instr_retired=0, halted=0.
- mem_req is registered. It rises on the first edge after reset deasserts (FETCH issues).
- Handshake:
  - While mem_req=1 and mem_ready=0, mem_addr, mem_we and mem_wdata are held stable and state is unchanged.
  - mem_ready sampled high completes the transaction that edge. mem_req drops the next cycle unless the next state also requests.
  - mem_ready while mem_req=0 is ignored.
- Latency with zero wait states:
  - beq and j: 3 cycles.
  - R-type, addi and sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle on a transaction adds 1 cycle.
- Reset asserted mid-transaction:
  - mem_req drops asynchronously and any in-flight write is abandoned.
  - Execution restarts at RESET_PC after deassertion.
- A register written in writeback is visible on dbg_data the cycle after the write edge.

## Configuration
- MC_MIPS_BNE_EN defined:
  - bne (opcode 0x05) is decoded. It goes to BRANCH with the compare inverted: branch if A!=B. Same 3-cycle latency.
- Undefined: opcode 0x05 is illegal and enters HALT.

## Test plan
- Reset/fetch, RESET_PC=0x100 with zero-wait memory:
  - First mem_req has mem_addr=0x100.
  - Asserting reset during a stalled fetch drops mem_req immediately.
- ALU, with $1=5 and $2=-3:
  - add $3 -> 2; sub $4 -> 8; slt $5,$2,$1 -> 1; and/or match golden values.
  - Each instruction retires every 4 cycles.
- Memory round trip:
  - addi $1,$0,0x40, then sw $1,8($1), then lw $6,8($1).
  - Required: a write of 0x40 at address 0x48, then $6=0x40. Add 3 wait cycles per transaction and check the lw takes 5+6 cycles.
- Control flow:
  - beq $0,$0,-1 loops to itself, with PC observed repeating.
  - j 0x0000010 makes the next fetch address 0x40.
  - beq not taken falls through to PC+4.
- Illegal and $0 behaviour:
  - addi $0,$0,7 leaves dbg_data(0)=0.
  - Opcode 0x3F sets halted=1 with no further mem_req.
  - With MC_MIPS_BNE_EN, bne with $1≠$2 is taken; without it, the same word halts.
